// File: rtl/mem_access_unit_if.sv
// Word-wide memory port between the load/store unit and memory.
// No internal state; signals pass straight through.
// The unit holds mem_req and payload stable until mem_ready.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Load/store unit side: issues requests, consumes ready/rdata.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wmask,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  // Memory side: accepts requests, returns ready/rdata.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wmask,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store stage: byte address in, word memory access out, load data extended.
// start at edge N -> mem_req in cycle N+1; done one cycle after mem_ready (N+2 best case).
// mem_req held until mem_ready or timeout; start is ignored while busy.
module mem_access_unit #(
  parameter logic [6:0]  LTYPE   = 7'b0000011,
  parameter logic [6:0]  STYPE   = 7'b0100011,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [6:0]               opcode_i,
  input  logic [2:0]               func3_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              store_data_i,
  mem_access_unit_if.master        mem,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              load_data_o,
  output logic [1:0]               err_code_o
);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  // One spare count beyond TIMEOUT so the counter can saturate without wrapping.
  localparam int unsigned    CW      = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0]  TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  state_e         state_q;
  logic           mem_req_q;
  logic           mem_we_q;
  logic [31:0]    mem_addr_q;
  logic [3:0]     mem_wmask_q;
  logic [31:0]    mem_wdata_q;
  logic           busy_q;
  logic           done_q;
  logic [31:0]    load_data_q;
  logic [1:0]     err_code_q;
  logic [2:0]     func3_q;
  logic [1:0]     off_q;
  logic [CW-1:0]  cnt_q;

  // Decoded view of the access presented on start
  logic           is_ld;
  logic           is_st;
  logic           legal_d;
  logic           misal_d;
  logic           fault_d;
  logic [1:0]     err_d;
  logic           we_d;
  logic [3:0]     mask_d;
  logic [31:0]    wdata_d;

  // Load path
  logic [31:0]    lane;
  logic [31:0]    load_ext_d;

  // Classify the incoming access and build store lanes/data.
  always_comb begin
    is_ld   = (opcode_i == LTYPE);
    is_st   = (opcode_i == STYPE);
    legal_d = 1'b0;
    misal_d = 1'b0;
    mask_d  = 4'b0000;
    wdata_d = 32'h0;
    we_d    = is_st;

    if (is_ld) begin
      legal_d = (func3_i == 3'b000) || (func3_i == 3'b001) || (func3_i == 3'b010) ||
                (func3_i == 3'b100) || (func3_i == 3'b101);
    end else if (is_st) begin
      legal_d = (func3_i == 3'b000) || (func3_i == 3'b001) || (func3_i == 3'b010);
    end

    // func3[1:0] encodes the access size for every legal encoding.
    case (func3_i[1:0])
      2'b01:   misal_d = addr_i[0];
      2'b10:   misal_d = (addr_i[1:0] != 2'b00);
      default: misal_d = 1'b0;
    endcase

    if (is_st) begin
      case (func3_i[1:0])
        2'b00: begin
          mask_d  = 4'b0001 << addr_i[1:0];
          wdata_d = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          mask_d  = 4'b0011 << addr_i[1:0];
          wdata_d = {2{store_data_i[15:0]}};
        end
        default: begin
          mask_d  = 4'b1111;
          wdata_d = store_data_i;
        end
      endcase
    end

    // An illegal encoding has no meaningful size, so it outranks misalignment.
    if (!legal_d) begin
      err_d = ERR_ILLEGAL;
    end else if (misal_d) begin
      err_d = ERR_MISALIGN;
    end else begin
      err_d = ERR_OK;
    end
    fault_d = !legal_d || misal_d;
  end

  // Shift the addressed lane down and extend it according to the latched func3.
  always_comb begin
    lane = mem.mem_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  load_ext_d = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext_d = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext_d = {24'h0, lane[7:0]};
      3'b101:  load_ext_d = {16'h0, lane[15:0]};
      default: load_ext_d = mem.mem_rdata;
    endcase
  end

  // Access sequencer; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= 32'h0;
      err_code_q  <= ERR_OK;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            if (fault_d) begin
              // Faults skip the memory entirely and report on the next cycle.
              state_q    <= S_RESP;
              done_q     <= 1'b1;
              err_code_q <= err_d;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_d;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_wmask_q <= mask_d;
              mem_wdata_q <= wdata_d;
              func3_q     <= func3_i;
              off_q       <= addr_i[1:0];
              cnt_q       <= '0;
            end
          end
        end

        S_REQ: begin
          if (mem.mem_ready) begin
            // A ready in the last counted cycle completes normally.
            state_q    <= S_RESP;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b1;
            err_code_q <= ERR_OK;
            if (!mem_we_q) begin
              load_data_q <= load_ext_d;
            end
          end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
            state_q    <= S_RESP;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wmask = mem_wmask_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign load_data_o = load_data_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a bench-driven memory port.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Memory readiness is set per vector to exercise waits and timeouts.
module tb_mem_access_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] sd;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errs   = 0;

  mem_access_unit_if mif ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .opcode_i     (opcode),
    .func3_i      (func3),
    .addr_i       (addr),
    .store_data_i (sd),
    .mem          (mif),
    .busy_o       (busy),
    .done_o       (done),
    .load_data_o  (load_data),
    .err_code_o   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of cycle N+1.
  task automatic launch(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    opcode = op;
    func3  = f3;
    addr   = a;
    sd     = d;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; opcode = '0; func3 = '0; addr = '0; sd = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);

    check("rst_req",   mif.mem_req,   0);
    check("rst_we",    mif.mem_we,    0);
    check("rst_addr",  mif.mem_addr,  0);
    check("rst_mask",  mif.mem_wmask, 0);
    check("rst_wdata", mif.mem_wdata, 0);
    check("rst_busy",  busy,          0);
    check("rst_done",  done,          0);
    check("rst_load",  load_data,     0);
    check("rst_err",   err_code,      0);
    rst = 1'b0;
    @(negedge clk);

    // lb from the top byte, memory ready immediately
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'h80AABBCC;
    launch(LD, 3'b000, 32'h0000_1003, 32'h0);
    check("lb_req",   mif.mem_req,   1);
    check("lb_addr",  mif.mem_addr,  32'h0000_1000);
    check("lb_we",    mif.mem_we,    0);
    check("lb_mask",  mif.mem_wmask, 0);
    check("lb_busy",  busy,          1);
    check("lb_done_early", done,     0);
    @(negedge clk);
    check("lb_done",  done,          1);
    check("lb_data",  load_data,     32'hFFFF_FF80);
    check("lb_err",   err_code,      0);
    check("lb_req_off", mif.mem_req, 0);
    @(negedge clk);
    check("lb_done_pulse", done,     0);
    check("lb_idle",  busy,          0);

    // lhu / lh on the upper halfword
    mif.mem_rdata = 32'h80011234;
    launch(LD, 3'b101, 32'h0000_2002, 32'h0);
    @(negedge clk);
    check("lhu_data", load_data,     32'h0000_8001);
    @(negedge clk);
    launch(LD, 3'b001, 32'h0000_2002, 32'h0);
    @(negedge clk);
    check("lh_data",  load_data,     32'hFFFF_8001);
    @(negedge clk);

    // illegal opcode: immediate done, no request, load_data held
    launch(7'b0110011, 3'b000, 32'h10, 32'h0);
    check("ill_op_done", done,       1);
    check("ill_op_req",  mif.mem_req, 0);
    check("ill_op_err",  err_code,   3);
    check("ill_op_hold", load_data,  32'hFFFF_8001);
    @(negedge clk);
    launch(LD, 3'b011, 32'h10, 32'h0);
    check("ill_f3_err",  err_code,   3);
    @(negedge clk);
    launch(ST, 3'b100, 32'h10, 32'h0);
    check("ill_sf3_err", err_code,   3);
    @(negedge clk);

    // sw with three wait cycles; ready arrives in the 4th (last counted) cycle
    mif.mem_ready = 1'b0;
    launch(ST, 3'b010, 32'h0000_0100, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sw_req%0d", i),   mif.mem_req,   1);
      check($sformatf("sw_wdata%0d", i), mif.mem_wdata, 32'hDEADBEEF);
      check($sformatf("sw_mask%0d", i),  mif.mem_wmask, 4'b1111);
      @(negedge clk);
    end
    check("sw_req3",  mif.mem_req,   1);
    check("sw_we",    mif.mem_we,    1);
    mif.mem_ready = 1'b1;
    @(negedge clk);
    check("sw_done",  done,          1);
    check("sw_err",   err_code,      0);
    check("sw_req_off", mif.mem_req, 0);
    @(negedge clk);

    // sb / sh lane placement, then misaligned sh
    launch(ST, 3'b000, 32'h0000_0202, 32'h0000_00A5);
    check("sb_mask",  mif.mem_wmask, 4'b0100);
    check("sb_wdata", mif.mem_wdata, 32'hA5A5A5A5);
    check("sb_addr",  mif.mem_addr,  32'h0000_0200);
    @(negedge clk);
    check("sb_done",  done,          1);
    @(negedge clk);
    launch(ST, 3'b001, 32'h0000_0102, 32'h1234BEEF);
    check("sh_mask",  mif.mem_wmask, 4'b1100);
    check("sh_wdata", mif.mem_wdata, 32'hBEEFBEEF);
    @(negedge clk);
    @(negedge clk);
    launch(ST, 3'b001, 32'h0000_0103, 32'h0);
    check("shm_done", done,          1);
    check("shm_req",  mif.mem_req,   0);
    check("shm_err",  err_code,      1);
    @(negedge clk);
    launch(LD, 3'b010, 32'h0000_0302, 32'h0);
    check("lwm_err",  err_code,      1);
    @(negedge clk);

    // timeout with a stray start during REQ
    mif.mem_ready = 1'b0;
    launch(LD, 3'b010, 32'h0000_0300, 32'h0);
    check("to_req1",  mif.mem_req,   1);
    @(negedge clk);
    opcode = ST; func3 = 3'b000; addr = 32'h400; sd = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("to_addr_kept", mif.mem_addr, 32'h0000_0300);
    check("to_we_kept",   mif.mem_we,   0);
    check("to_req3",  mif.mem_req,   1);
    @(negedge clk);
    check("to_req4",  mif.mem_req,   1);
    check("to_done_early", done,     0);
    @(negedge clk);
    check("to_done",  done,          1);
    check("to_err",   err_code,      2);
    check("to_req_off", mif.mem_req, 0);
    @(negedge clk);
    check("to_idle",  busy,          0);
    @(negedge clk);
    check("to_no_ghost", mif.mem_req, 0);

    // reset during the 2nd REQ cycle abandons the access
    launch(LD, 3'b010, 32'h0000_0500, 32'h0);
    check("rr_req1",  mif.mem_req,   1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_req",   mif.mem_req,   0);
    check("rr_busy",  busy,          0);
    check("rr_err",   err_code,      0);
    dones = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("rr_no_done", dones, 0);

    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'h12345678;
    launch(LD, 3'b010, 32'h0000_0504, 32'h0);
    check("rr_lw_addr", mif.mem_addr, 32'h0000_0504);
    @(negedge clk);
    check("rr_lw_done", done,        1);
    check("rr_lw_data", load_data,   32'h12345678);
    check("rr_lw_err",  err_code,    0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
